jtpopeye_rom_arb: RTL and testbench
===================================

JTPOPEYE_ROM_ARB -- requirements
Module: jtpopeye_rom_arb

Interface
REQ-001 Parameters (name, default, meaning):
- SLOTS, 2, number of ROM client channels (1..4).
- SLOT_AW, 15, per-slot address width, in 32-bit words.
- OFFSETS, 88'h0, packed SLOTS x 22-bit SDRAM base word address per slot; slot i occupies bits [22*i+21:22*i].
- READY_DLY, 16, clk cycles from downloading falling to ready rising.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, 20 MHz system clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- downloading, in, 1, ROM load in progress.
- loop_rst, in, 1, SDRAM loop reset.
- slot_cs, in, SLOTS, per-slot read request.
- slot_addr, in, SLOTS*SLOT_AW, per-slot word address.
- slot_dout, out, SLOTS*32, per-slot cached data word.
- slot_ok, out, SLOTS, slot_dout valid for the current slot_addr.
- sdram_req, out, 1, SDRAM read request.
- sdram_addr, out, 22, SDRAM word address.
- sdram_ack, in, 1, SDRAM accepted request.
- data_rdy, in, 1, data_read valid.
- data_read, in, 32, SDRAM read data.
- refresh_en, out, 1, SDRAM may refresh.
- ready, out, 1, arbiter is serving reads.

Function
REQ-003 Each slot holds one cache line: tag (SLOT_AW bits), data (32 bits), valid.
REQ-004 Hit = slot_cs & valid & (tag == slot_addr); slot_ok is registered and rises one clk after a hit.
REQ-005 slot_ok falls in the same clk that slot_addr changes to a non-matching value or slot_cs falls; this path is combinational off the registered hit.
REQ-006 FSM states: IDLE, REQ, WAIT.
- IDLE -> REQ when ready and any slot misses.
- REQ -> WAIT on sdram_ack.
- WAIT -> IDLE on data_rdy.
REQ-007 Arbitration is round-robin: the search starts at the slot after the last one served; the winner's slot_addr is latched on IDLE->REQ.
REQ-008 sdram_addr = OFFSETS[winner] + zero-extended latched address, modulo 2^22 (wrap, no saturation).
REQ-009 sdram_req is high throughout REQ only.
REQ-010 On data_rdy in WAIT: data_read, the latched tag and valid=1 are written to the winner's line; slot_ok rises on the next clk if the address is unchanged.
REQ-011 If the winner's slot_addr changes during WAIT, the line is still filled with the latched tag; the slot then misses again and is re-requested.
REQ-012 refresh_en = (state==IDLE) & no slot missing, registered.
REQ-013 data_rdy outside WAIT is ignored; sdram_ack outside REQ is ignored.
REQ-014 Full-miss throughput: with every slot missing, each slot is served within SLOTS SDRAM transactions.
REQ-015 ready falls on the clk after downloading rises; it rises READY_DLY clks after downloading falls. While ready is low: no requests, all valid bits cleared.
REQ-016 loop_rst high: FSM forced to IDLE, sdram_req low, all valid bits cleared, round-robin pointer kept.

Reset
REQ-017 rst_n low asynchronously sets:
- FSM to IDLE; round-robin pointer to slot 0.
- sdram_req=0, slot_ok=0, valid=0, ready=0, refresh_en=1.
- sdram_addr=0, slot_dout=0.
REQ-018 Reset asserted mid-transaction abandons it; no fill occurs.

Configuration
REQ-019 With JTPOPEYE_ROMARB_STATS_EN defined:
- extra output miss_cnt (16 bits) is present;
- it increments on every IDLE->REQ transition, saturates at 16'hFFFF, and clears on rst_n or loop_rst.
Without the macro, the port and its counter are absent and all other behaviour is identical.

Verification
REQ-020 SLOTS=2, ready, slot0 addr 15'h0010 miss; sdram acks at clk+2, data_rdy at clk+5 with 32'hDEADBEEF -> sdram_addr=OFFSETS[0]+0x10, slot_dout[31:0]=DEADBEEF, slot_ok[0] rises 1 clk after data_rdy.
REQ-021 Both slots miss simultaneously, last served = slot1 -> slot0 is served first, slot1 second; refresh_en goes high only after the second fill.
REQ-022 Slot1 offset 22'h3FFFF0 with addr 15'h0020 -> sdram_addr=22'h000010 (wrap).
REQ-023 Slot0 addr changes 0x10->0x11 during WAIT -> line filled with tag 0x10, slot_ok[0] stays 0, and a second request is issued for 0x11.
REQ-024 Pulse downloading for 1 clk -> ready low, valids cleared, ready high exactly 16 clks after downloading falls; reset during WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/jtpopeye_rom_arb.sv
// Purpose: per-slot one-line ROM cache with a round-robin SDRAM read arbiter; optional miss counter (JTPOPEYE_ROMARB_STATS_EN).
// Latency: a miss issues sdram_req one clk after it appears; slot_ok rises one clk after the fill.
// Backpressure: the request is held until sdram_ack, then the arbiter waits for data_rdy; clients simply wait for slot_ok.
// Ports: clk/rst_n (async, active-low), downloading/loop_rst control, slot_cs/slot_addr -> slot_dout/slot_ok client side,
//        sdram_req/sdram_addr/sdram_ack/data_rdy/data_read SDRAM side, refresh_en and ready status,
//        miss_cnt (16 bits) only when JTPOPEYE_ROMARB_STATS_EN is defined.
module jtpopeye_rom_arb #(
    parameter int          SLOTS     = 2,
    parameter int          SLOT_AW   = 15,
    parameter logic [87:0] OFFSETS   = 88'h0,
    parameter int          READY_DLY = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    downloading,
    input  logic                    loop_rst,
    input  logic [SLOTS-1:0]        slot_cs,
    input  logic [SLOTS*SLOT_AW-1:0] slot_addr,
    output logic [SLOTS*32-1:0]     slot_dout,
    output logic [SLOTS-1:0]        slot_ok,
    output logic                    sdram_req,
    output logic [21:0]             sdram_addr,
    input  logic                    sdram_ack,
    input  logic                    data_rdy,
    input  logic [31:0]             data_read,
    output logic                    refresh_en,
`ifdef JTPOPEYE_ROMARB_STATS_EN
    output logic [15:0]             miss_cnt,
`endif
    output logic                    ready
);

    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CW = $clog2(READY_DLY + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t               state, state_nxt;
    logic [SLOTS-1:0]     valid, hit_r, addr_eq, miss;
    logic [SLOT_AW-1:0]   tag [SLOTS];
    logic [SLOT_AW-1:0]   lat_addr;
    logic [PW-1:0]        last, winner;
    logic [PW:0]          sidx;
    logic                 found, any_miss, take, fill;
    logic [CW-1:0]        rdy_cnt;

    // Tag compare and miss detection per slot.
    always_comb begin
        addr_eq = '0;
        miss    = '0;
        for (int i = 0; i < SLOTS; i++) begin
            addr_eq[i] = (tag[i] == slot_addr[i*SLOT_AW +: SLOT_AW]);
            miss[i]    = slot_cs[i] & ~(valid[i] & addr_eq[i]);
        end
    end

    assign any_miss = |miss;

    // slot_ok drops combinationally when the address moves away or cs falls.
    assign slot_ok = hit_r & slot_cs & valid & addr_eq;

    // Round-robin search starting at the slot after the last one served.
    always_comb begin
        winner = last;
        found  = 1'b0;
        sidx   = '0;
        for (int k = 1; k <= SLOTS; k++) begin
            sidx = {1'b0, last} + (PW+1)'(k);
            if (sidx >= (PW+1)'(SLOTS))
                sidx = sidx - (PW+1)'(SLOTS);
            if (!found && miss[sidx[PW-1:0]]) begin
                winner = sidx[PW-1:0];
                found  = 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state. loop_rst and a not-ready arbiter abandon any transaction.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ready && any_miss) state_nxt = REQ;
            REQ:     if (sdram_ack)         state_nxt = WAIT;
            WAIT:    if (data_rdy)          state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
        if (loop_rst || !ready)
            state_nxt = IDLE;
    end

    // FSM: outputs
    always_comb begin
        sdram_req = (state == REQ) && ready && !loop_rst;
    end

    assign take = (state == IDLE) && (state_nxt == REQ);
    assign fill = (state == WAIT) && data_rdy && ready && !loop_rst;

    // Cache lines, request address and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last       <= '0;
            lat_addr   <= '0;
            sdram_addr <= '0;
            slot_dout  <= '0;
            valid      <= '0;
            hit_r      <= '0;
            refresh_en <= 1'b1;
            for (int i = 0; i < SLOTS; i++) tag[i] <= '0;
        end else begin
            if (take) begin
                last       <= winner;
                lat_addr   <= slot_addr[int'(winner)*SLOT_AW +: SLOT_AW];
                sdram_addr <= OFFSETS[int'(winner)*22 +: 22]
                            + 22'(slot_addr[int'(winner)*SLOT_AW +: SLOT_AW]);
            end
            // The latched tag is written even if the client address moved on.
            if (fill) begin
                tag[last]                   <= lat_addr;
                slot_dout[int'(last)*32 +: 32] <= data_read;
                valid[last]                 <= 1'b1;
            end
            if (loop_rst || !ready)
                valid <= '0;
            hit_r      <= slot_cs & valid & addr_eq;
            refresh_en <= (state == IDLE) && !any_miss;
        end
    end

    // ready: low the clk after downloading is seen, high READY_DLY clks after it falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready   <= 1'b0;
            rdy_cnt <= '0;
        end else if (downloading) begin
            ready   <= 1'b0;
            rdy_cnt <= '0;
        end else if (!ready) begin
            if (rdy_cnt == CW'(READY_DLY - 1))
                ready <= 1'b1;
            rdy_cnt <= rdy_cnt + 1'b1;
        end
    end

`ifdef JTPOPEYE_ROMARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            miss_cnt <= '0;
        else if (loop_rst)
            miss_cnt <= '0;
        else if (take && miss_cnt != 16'hFFFF)
            miss_cnt <= miss_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_jtpopeye_rom_arb.sv
// Purpose: directed self-checking bench for jtpopeye_rom_arb (SLOTS=2, slot0 base 0x001000, slot1 base 0x3FFFF0).
// Latency: inputs driven 1 time unit after posedge, outputs checked there before the next edge.
// Backpressure: SDRAM side modelled by directed ack/data_rdy pulses.
module tb_jtpopeye_rom_arb;

    localparam logic [87:0] OFFS = {44'h0, 22'h3FFFF0, 22'h001000};

    logic        clk = 1'b0;
    logic        rst_n, downloading, loop_rst;
    logic [1:0]  slot_cs;
    logic [29:0] slot_addr;
    logic [63:0] slot_dout;
    logic [1:0]  slot_ok;
    logic        sdram_req, sdram_ack, data_rdy, refresh_en, ready;
    logic [21:0] sdram_addr;
    logic [31:0] data_read;
`ifdef JTPOPEYE_ROMARB_STATS_EN
    logic [15:0] miss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    jtpopeye_rom_arb #(.SLOTS(2), .SLOT_AW(15), .OFFSETS(OFFS), .READY_DLY(16)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
        .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_dout(slot_dout), .slot_ok(slot_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en),
`ifdef JTPOPEYE_ROMARB_STATS_EN
        .miss_cnt(miss_cnt),
`endif
        .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, check its address, then ack and return data.
    task automatic serve(input string tag, input logic [21:0] exp_addr, input logic [31:0] d);
        int n = 0;
        while (!sdram_req && n < 40) begin
            tick;
            n++;
        end
        chk({tag, "_req"}, sdram_req, 1'b1);
        chk({tag, "_addr"}, sdram_addr, exp_addr);
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        tick;
        data_read = d;
        data_rdy  = 1'b1;
        tick;
        data_rdy  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
        slot_cs = 2'b00; slot_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        tick; tick;

        // Reset values
        chk("rst_req", sdram_req, 1'b0);
        chk("rst_ok", slot_ok, 2'b00);
        chk("rst_ready", ready, 1'b0);
        chk("rst_refresh", refresh_en, 1'b1);
        chk("rst_addr", sdram_addr, 22'h0);
        chk("rst_dout", slot_dout, 64'h0);

        rst_n = 1'b1;
        repeat (15) tick;
        chk("ready_early", ready, 1'b0);
        tick;
        chk("ready_16", ready, 1'b1);

        // Single miss on slot0 at 0x10
        slot_cs = 2'b01;
        slot_addr[0 +: 15] = 15'h0010;
        tick;
        chk("t1_req", sdram_req, 1'b1);
        chk("t1_addr", sdram_addr, 22'h001010);
        chk("t1_refresh", refresh_en, 1'b0);
        tick;
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        chk("t1_req_low_wait", sdram_req, 1'b0);
        tick; tick;
        data_read = 32'hDEADBEEF;
        data_rdy  = 1'b1;
        tick;
        data_rdy  = 1'b0;
        chk("t1_dout", slot_dout[31:0], 32'hDEADBEEF);
        chk("t1_ok_not_yet", slot_ok, 2'b00);
        tick;
        chk("t1_ok", slot_ok, 2'b01);
        chk("t1_refresh_hi", refresh_en, 1'b1);

        // Stray data_rdy / sdram_ack in IDLE are ignored
        data_read = 32'h0BADF00D;
        data_rdy  = 1'b1;
        sdram_ack = 1'b1;
        tick;
        data_rdy  = 1'b0;
        sdram_ack = 1'b0;
        chk("ign_dout", slot_dout[31:0], 32'hDEADBEEF);
        chk("ign_req", sdram_req, 1'b0);

        // slot_ok falls combinationally on address change or cs drop
        slot_addr[0 +: 15] = 15'h0011;
        #1;
        chk("ok_addr_fall", slot_ok[0], 1'b0);
        slot_addr[0 +: 15] = 15'h0010;
        #1;
        chk("ok_back", slot_ok[0], 1'b1);
        slot_cs = 2'b00;
        #1;
        chk("ok_cs_fall", slot_ok[0], 1'b0);
        slot_cs = 2'b01;
        tick;

        // Slot1 wraps: 0x3FFFF0 + 0x20
        slot_cs = 2'b11;
        slot_addr[15 +: 15] = 15'h0020;
        serve("wrap", 22'h000010, 32'h11112222);
        tick;
        chk("wrap_ok", slot_ok, 2'b11);
        chk("wrap_dout", slot_dout[63:32], 32'h11112222);

        // Both miss, last served slot1 -> slot0 first
        slot_addr[0 +: 15]  = 15'h0030;
        slot_addr[15 +: 15] = 15'h0040;
        serve("rr0", 22'h001030, 32'hA0A0A0A0);
        chk("rr_refresh_mid", refresh_en, 1'b0);
        serve("rr1", 22'h000030, 32'hB1B1B1B1);
        tick;
        chk("rr_refresh_end", refresh_en, 1'b1);
        chk("rr_ok", slot_ok, 2'b11);
        chk("rr_dout", slot_dout, 64'hB1B1B1B1_A0A0A0A0);

        // Address changes during WAIT
        slot_addr[0 +: 15] = 15'h0010;
        tick;
        chk("chg_addr", sdram_addr, 22'h001010);
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        slot_addr[0 +: 15] = 15'h0011;
        data_read = 32'hAAAA5555;
        data_rdy  = 1'b1;
        tick;
        data_rdy  = 1'b0;
        chk("chg_dout", slot_dout[31:0], 32'hAAAA5555);
        tick;
        chk("chg_ok0", slot_ok[0], 1'b0);
        serve("chg_re", 22'h001011, 32'hBBBB0011);
        tick;
        chk("chg_ok1", slot_ok[0], 1'b1);

        // loop_rst aborts a request, clears valids, keeps the pointer (last = slot1)
        slot_addr[15 +: 15] = 15'h0050;
        tick;
        chk("lr_req", sdram_req, 1'b1);
        chk("lr_addr", sdram_addr, 22'h000040);
        loop_rst = 1'b1;
        #1;
        chk("lr_req_low", sdram_req, 1'b0);
        tick;
        loop_rst = 1'b0;
        chk("lr_ok", slot_ok, 2'b00);
        serve("lr0", 22'h001011, 32'hC0C0C0C0);
        serve("lr1", 22'h000040, 32'hC1C1C1C1);
        tick;
        chk("lr_ok_end", slot_ok, 2'b11);

        // downloading pulse
        downloading = 1'b1;
        tick;
        downloading = 1'b0;
        chk("dl_ready_low", ready, 1'b0);
        repeat (15) tick;
        chk("dl_ready_15", ready, 1'b0);
        chk("dl_ok", slot_ok, 2'b00);
        chk("dl_noreq", sdram_req, 1'b0);
        tick;
        chk("dl_ready_16", ready, 1'b1);

        // Reset during WAIT
        begin
            int n = 0;
            while (!sdram_req && n < 40) begin
                tick;
                n++;
            end
        end
        chk("rw_req", sdram_req, 1'b1);
        chk("rw_addr", sdram_addr, 22'h001011);
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        data_read = 32'h12345678;
        data_rdy  = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("rw_req0", sdram_req, 1'b0);
        chk("rw_addr0", sdram_addr, 22'h0);
        chk("rw_dout0", slot_dout, 64'h0);
        chk("rw_ok0", slot_ok, 2'b00);
        chk("rw_ready0", ready, 1'b0);
        chk("rw_refresh1", refresh_en, 1'b1);
        tick;
        data_rdy = 1'b0;
        chk("rw_nofill", slot_dout, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
